// File: rtl/wb_pkg.sv
// Shared Wishbone types, widths and the round-robin pick used by the arbiter.
package wb_pkg;

   localparam int WB_DATA_W = 32;
   localparam int WB_ADDR_W = 32;
   localparam int WB_SEL_W  = WB_DATA_W / 8;
   localparam int MAX_M     = 8;
   localparam int PTR_W     = 3;

   typedef enum logic {
      IDLE    = 1'b0,
      GRANTED = 1'b1
   } arb_state_t;

   // One-hot grant for the first requester at or after ptr, wrapping modulo m.
   function automatic logic [MAX_M-1:0] rr_pick(input logic [MAX_M-1:0] req,
                                                input logic [PTR_W-1:0] ptr,
                                                input int m);
      logic [MAX_M-1:0] g;
      logic [PTR_W-1:0] idx;
      g = '0;
      for (int k = 0; k < MAX_M; k++) begin
         idx = PTR_W'((int'(ptr) + k) % m);
         if (k < m && g == '0 && req[idx]) g[idx] = 1'b1;
      end
      return g;
   endfunction

endpackage

// File: rtl/wb_bus.sv
// Classic Wishbone bus bundle; master drives the request side, slave the response side.
interface wb_bus;
   logic [wb_pkg::WB_ADDR_W-1:0] addr;
   logic [wb_pkg::WB_DATA_W-1:0] wdata;
   logic [wb_pkg::WB_DATA_W-1:0] rdata;
   logic [wb_pkg::WB_SEL_W-1:0]  sel;
   logic                         we;
   logic                         cyc;
   logic                         stb;
   logic                         ack;
   logic                         err;

   modport master (output addr, wdata, sel, we, cyc, stb, input ack, err, rdata);
   modport slave  (input addr, wdata, sel, we, cyc, stb, output ack, err, rdata);
endinterface

// File: rtl/wb_watchdog.sv
// Per-transfer watchdog: turns a strobe that is never answered into a one-cycle error pulse.
module wb_watchdog #(
   parameter int TimeoutCycles = 255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic enable_i,
   input  logic stb_i,
   input  logic ack_i,
   input  logic err_i,
   output logic fire_o
);

   localparam int CW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
   localparam logic [CW-1:0] LIMIT   = CW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
   localparam logic [CW-1:0] CNT_MAX = '1;

   logic [CW-1:0] wdog_cnt;
   logic          fire_q;
   logic          pending;

   assign pending = enable_i & stb_i & ~ack_i & ~err_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wdog_cnt <= '0;
         fire_q   <= 1'b0;
      end else if (TimeoutCycles == 0) begin
         wdog_cnt <= '0;
         fire_q   <= 1'b0;
      end else begin
         fire_q <= pending && (wdog_cnt == LIMIT);
         if (!pending || wdog_cnt == LIMIT) wdog_cnt <= '0;
         else if (wdog_cnt != CNT_MAX)      wdog_cnt <= wdog_cnt + CW'(1);
      end
   end

   // A late ack landing on the firing cycle wins over the timeout.
   assign fire_o = fire_q & ~ack_i;

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin M:1 Wishbone arbiter; the winner keeps the bus for its whole cyc burst.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int M             = 2,
   parameter int TimeoutCycles = 255
) (
   input  logic         clk_i,
   input  logic         rst_i,
   wb_bus.slave         bus_in [M-1:0],
   wb_bus.master        bus_out,
   output logic [M-1:0] grant_o,
   output logic         timeout_o,
   output arb_state_t   state_o
);

   arb_state_t       state, state_nxt;
   logic [M-1:0]     grant_q, grant_nxt, req;
   logic [PTR_W-1:0] rr_ptr, rr_ptr_nxt, owner;
   logic [MAX_M-1:0] pick;
   logic             pick_unused;
   logic             wd_err;

   logic [WB_ADDR_W-1:0] m_addr  [M];
   logic [WB_DATA_W-1:0] m_wdata [M];
   logic [WB_SEL_W-1:0]  m_sel   [M];
   logic                 m_we    [M];
   logic                 m_cyc   [M];
   logic                 m_stb   [M];

   logic [WB_ADDR_W-1:0] out_addr;
   logic [WB_DATA_W-1:0] out_wdata;
   logic [WB_SEL_W-1:0]  out_sel;
   logic                 out_we, out_cyc, out_stb;

   // Interface arrays are only touched with a constant index, inside this loop.
   for (genvar i = 0; i < M; i++) begin : g_port
      always_comb begin
         m_addr[i]  = bus_in[i].addr;
         m_wdata[i] = bus_in[i].wdata;
         m_sel[i]   = bus_in[i].sel;
         m_we[i]    = bus_in[i].we;
         m_cyc[i]   = bus_in[i].cyc;
         m_stb[i]   = bus_in[i].stb;
      end
      always_comb begin
         bus_in[i].ack   = grant_q[i] & bus_out.ack;
         bus_in[i].err   = grant_q[i] & (bus_out.err | wd_err);
         bus_in[i].rdata = grant_q[i] ? bus_out.rdata : '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= IDLE;
         grant_q <= '0;
         rr_ptr  <= '0;
      end else begin
         state   <= state_nxt;
         grant_q <= grant_nxt;
         rr_ptr  <= rr_ptr_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      grant_nxt  = grant_q;
      rr_ptr_nxt = rr_ptr;
      req        = '0;
      owner      = '0;
      for (int i = 0; i < M; i++) begin
         req[i] = m_cyc[i];
         if (grant_q[i]) owner = PTR_W'(i);
      end
      pick = rr_pick(MAX_M'(req), rr_ptr, M);
      case (state)
         IDLE: begin
            if (|req) begin
               state_nxt = GRANTED;
               grant_nxt = pick[M-1:0];
            end
         end
         GRANTED: begin
            // The releasing master moves to the back of the next round.
            if (!(|(req & grant_q))) begin
               state_nxt  = IDLE;
               grant_nxt  = '0;
               rr_ptr_nxt = (owner == PTR_W'(M - 1)) ? '0 : owner + PTR_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            grant_nxt = '0;
         end
      endcase
   end

   assign pick_unused = ^pick;

   always_comb begin
      out_addr  = '0;
      out_wdata = '0;
      out_sel   = '0;
      out_we    = 1'b0;
      out_cyc   = 1'b0;
      out_stb   = 1'b0;
      for (int i = 0; i < M; i++) begin
         if (grant_q[i]) begin
            out_addr  = out_addr  | m_addr[i];
            out_wdata = out_wdata | m_wdata[i];
            out_sel   = out_sel   | m_sel[i];
            out_we    = out_we    | m_we[i];
            out_cyc   = out_cyc   | m_cyc[i];
            out_stb   = out_stb   | m_stb[i];
         end
      end
   end

   assign bus_out.addr  = out_addr;
   assign bus_out.wdata = out_wdata;
   assign bus_out.sel   = out_sel;
   assign bus_out.we    = out_we;
   assign bus_out.cyc   = out_cyc;
   assign bus_out.stb   = out_stb;

   wb_watchdog #(.TimeoutCycles(TimeoutCycles)) u_wdog (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .enable_i (state == GRANTED),
      .stb_i    (out_stb),
      .ack_i    (bus_out.ack),
      .err_i    (bus_out.err),
      .fire_o   (wd_err)
   );

   assign grant_o   = grant_q;
   assign timeout_o = wd_err;
   assign state_o   = state;

endmodule
